// File: rtl/alu_pkg.sv
// Shared types and constants for the wide ALU sequencer and its 32-bit datapath.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] ALU_SEL_ADD = 4'h0;
  localparam logic [3:0] ALU_SEL_SUB = 4'h1;
  localparam logic [3:0] ALU_SEL_AND = 4'h2;
  localparam logic [3:0] ALU_SEL_OR  = 4'h3;
  localparam logic [3:0] ALU_SEL_XOR = 4'h4;

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU: add/sub with carry chain, bitwise logic ops.
// Zero latency; no flow control. Logic ops report cout=0.
module alu_32bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic             cin_i,
  input  logic [3:0]       sel_i,
  output logic [ALU_W-1:0] f_o,
  output logic             cout_o
);

  logic [ALU_W:0] sum;

  always_comb begin
    sum    = '0;
    f_o    = '0;
    cout_o = 1'b0;
    case (sel_i)
      ALU_SEL_ADD: begin
        sum    = {1'b0, a_i} + {1'b0, b_i} + {{ALU_W{1'b0}}, cin_i};
        f_o    = sum[ALU_W-1:0];
        cout_o = sum[ALU_W];
      end
      ALU_SEL_SUB: begin
        sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{ALU_W{1'b0}}, cin_i};
        f_o    = sum[ALU_W-1:0];
        cout_o = sum[ALU_W];
      end
      ALU_SEL_AND: f_o = a_i & b_i;
      ALU_SEL_OR:  f_o = a_i | b_i;
      ALU_SEL_XOR: f_o = a_i ^ b_i;
      default:     f_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_wide_seq.sv
// Sequences NWORDS*32-bit ops through an external 32-bit ALU, LSW first, carry chained.
// Latency NWORDS cycles accept->rsp_valid; response held until rsp_ready, no accept while held.
module alu_wide_seq
  import alu_pkg::*;
#(
  parameter int NWORDS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [NWORDS*ALU_W-1:0] req_a_i,
  input  logic [NWORDS*ALU_W-1:0] req_b_i,
  input  logic                    req_cin_i,
  input  logic [3:0]              req_sel_i,
  output logic [ALU_W-1:0]        alu_a_o,
  output logic [ALU_W-1:0]        alu_b_o,
  output logic                    alu_cin_o,
  output logic [3:0]              alu_sel_o,
  input  logic [ALU_W-1:0]        alu_f_i,
  input  logic                    alu_cout_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [NWORDS*ALU_W-1:0] rsp_f_o,
  output logic                    rsp_cout_o,
  output logic                    rsp_zero_o,
  output logic                    busy_o
);

  localparam int W  = NWORDS * ALU_W;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic [3:0]      sel_q;
  logic            carry;
  logic            cout_q;
  logic [IW-1:0]   widx;
  logic            accept;

  assign req_ready_o = (state == IDLE) | ((state == DONE) & rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  assign alu_a_o     = (state == EXEC) ? a_q[widx*ALU_W +: ALU_W] : '0;
  assign alu_b_o     = (state == EXEC) ? b_q[widx*ALU_W +: ALU_W] : '0;
  assign alu_cin_o   = (state == EXEC) ? carry : 1'b0;
  assign alu_sel_o   = sel_q;

  assign rsp_valid_o = (state == DONE);
  assign rsp_f_o     = res_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_zero_o  = (state == DONE) & ~|res_q;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      sel_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      widx   <= '0;
    end else begin
      if (state == EXEC) begin
        res_q[widx*ALU_W +: ALU_W] <= alu_f_i;
        carry                      <= alu_cout_i;
        if (widx == LAST) begin
          state  <= DONE;
          cout_q <= alu_cout_i;
          widx   <= '0;
        end else begin
          widx <= widx + IW'(1);
        end
      end
      // Accept from IDLE, or straight out of DONE when the response drains the same cycle.
      if (accept) begin
        a_q   <= req_a_i;
        b_q   <= req_b_i;
        sel_q <= req_sel_i;
        carry <= req_cin_i;
        widx  <= '0;
        state <= EXEC;
      end else if ((state == DONE) && rsp_ready_i) begin
        state <= IDLE;
      end
    end
  end

endmodule
